wr1_rdn_addr_arb: RTL and testbench

WR1_RDN_ADDR_ARB -- requirements
Module: wr1_rdn_addr_arb

---
 rtl/wr1_rdn_addr_arb.sv | 129 ++++++++++++
 tb/tb_wr1_rdn_addr_arb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wr1_rdn_addr_arb.sv
// Frame buffer address arbiter: one writer, RD_NUM readers sharing BUF_NUM buffers.
// The writer always owns a buffer that no reader holds; each reader latches the most
// recently completed frame on its own frame sync, or reports a repeat when no newer
// frame exists.
module wr1_rdn_addr_arb #(
    parameter int unsigned           ADDR_BITS  = 25,
    parameter int unsigned           BUF_NUM    = 4,
    parameter int unsigned           RD_NUM     = 2,
    parameter logic [ADDR_BITS-1:0]  BASE_ADDR  = 25'h0,
    parameter logic [ADDR_BITS-1:0]  FRAME_SIZE = 25'h10_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        write_vs,
    input  logic                        write_enable,
    input  logic [RD_NUM-1:0]           read_vs,
    output logic [ADDR_BITS-1:0]        write_base,
    output logic [RD_NUM*ADDR_BITS-1:0] read_base,
    output logic [RD_NUM-1:0]           read_repeat,
    output logic                        frame_drop
);

    localparam int unsigned      IDX_W    = $clog2(BUF_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_NUM - 1);

    function automatic logic [ADDR_BITS-1:0] addr_of(input logic [IDX_W-1:0] idx);
        return BASE_ADDR + ADDR_BITS'(idx) * FRAME_SIZE;
    endfunction

    logic                write_vs_d;
    logic [RD_NUM-1:0]   read_vs_d;
    logic                write_edge;
    logic                write_commit;
    logic [RD_NUM-1:0]   read_edge;

    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    wr_next;
    logic [IDX_W-1:0]    latest_idx;
    logic                latest_valid;
    logic [IDX_W-1:0]    rd_idx [RD_NUM];

    logic [IDX_W-1:0]    cand;
    logic                busy;
    logic                found;

    // Edges are gated by enable, but the delayed samples are not, so a sync held
    // high across enable rising does not produce a late edge.
    assign write_edge   = enable & write_vs & ~write_vs_d;
    assign read_edge    = {RD_NUM{enable}} & read_vs & ~read_vs_d;
    assign write_commit = write_edge & write_enable;

    // Next write buffer: first index after wr_idx (cyclically) not held by any reader.
    always_comb begin
        wr_next = wr_idx;
        cand    = '0;
        busy    = 1'b0;
        found   = 1'b0;
        for (int unsigned s = 1; s < BUF_NUM; s++) begin
            cand = IDX_W'((32'(wr_idx) + s) % BUF_NUM);
            busy = 1'b0;
            for (int unsigned k = 0; k < RD_NUM; k++) begin
                if (rd_idx[k] == cand) begin
                    busy = 1'b1;
                end
            end
            if (!found && !busy) begin
                wr_next = cand;
                found   = 1'b1;
            end
        end
    end

    // Sync sampling, index state and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_vs_d   <= 1'b0;
            read_vs_d    <= '0;
            wr_idx       <= '0;
            latest_idx   <= '0;
            latest_valid <= 1'b0;
            frame_drop   <= 1'b0;
            read_repeat  <= '0;
            for (int unsigned k = 0; k < RD_NUM; k++) begin
                rd_idx[k] <= LAST_IDX;
            end
        end else begin
            write_vs_d <= write_vs;
            read_vs_d  <= read_vs;
            frame_drop <= write_edge & ~write_enable;
            if (write_commit) begin
                latest_idx   <= wr_idx;
                latest_valid <= 1'b1;
                wr_idx       <= wr_next;
            end
            // A reader syncing on the same edge as a completed write takes the
            // buffer just finished (old wr_idx); it never equals the reader's own
            // index, so that case can never be a repeat.
            for (int unsigned k = 0; k < RD_NUM; k++) begin
                read_repeat[k] <= 1'b0;
                if (read_edge[k]) begin
                    if (write_commit) begin
                        rd_idx[k] <= wr_idx;
                    end else if (latest_valid && (latest_idx != rd_idx[k])) begin
                        rd_idx[k] <= latest_idx;
                    end else begin
                        read_repeat[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // Registered base addresses, forced to BASE_ADDR while arbitration is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_base <= BASE_ADDR;
            for (int unsigned k = 0; k < RD_NUM; k++) begin
                read_base[k*ADDR_BITS +: ADDR_BITS] <= addr_of(LAST_IDX);
            end
        end else begin
            write_base <= enable ? addr_of(wr_idx) : BASE_ADDR;
            for (int unsigned k = 0; k < RD_NUM; k++) begin
                read_base[k*ADDR_BITS +: ADDR_BITS] <= enable ? addr_of(rd_idx[k]) : BASE_ADDR;
            end
        end
    end

endmodule

// File: tb/tb_wr1_rdn_addr_arb.sv
// Self-checking bench for wr1_rdn_addr_arb: directed scenarios followed by random
// frame syncs, all compared against a cycle-level behavioural model.
module tb_wr1_rdn_addr_arb;

    localparam int AB    = 25;
    localparam int BN    = 4;
    localparam int RN    = 2;
    localparam int BASE  = 0;
    localparam int FRAME = 32'h10_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              wvs;
    logic              wen;
    logic [RN-1:0]     rvs;
    logic [AB-1:0]     write_base;
    logic [RN*AB-1:0]  read_base;
    logic [RN-1:0]     read_repeat;
    logic              frame_drop;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int m_wr, m_latest, m_lv;
    int m_rd [RN];
    logic p_wvs;
    logic [RN-1:0] p_rvs;
    int frames;

    wr1_rdn_addr_arb #(
        .ADDR_BITS (25),
        .BUF_NUM   (4),
        .RD_NUM    (2),
        .BASE_ADDR (25'h0),
        .FRAME_SIZE(25'h10_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (en),
        .write_vs    (wvs),
        .write_enable(wen),
        .read_vs     (rvs),
        .write_base  (write_base),
        .read_base   (read_base),
        .read_repeat (read_repeat),
        .frame_drop  (frame_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [AB-1:0] addr(input int idx);
        return AB'(BASE + idx * FRAME);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_latest = 0; m_lv = 0;
        for (int k = 0; k < RN; k++) m_rd[k] = BN - 1;
        p_wvs = 1'b0; p_rvs = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wvs = 1'b0; rvs = '0; wen = 1'b1;
        #2;
        model_reset();
        chk("rst_wb",   write_base,  64'h0);
        chk("rst_rb",   read_base,   {25'h30_0000, 25'h30_0000});
        chk("rst_rep",  read_repeat, 64'h0);
        chk("rst_drop", frame_drop,  64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One clock: predict from the rules, advance, then compare all outputs.
    task automatic tick();
        logic             we, commit, re;
        logic [AB-1:0]    e_wb;
        logic [RN*AB-1:0] e_rb;
        logic [RN-1:0]    e_rep;
        logic             e_drop;
        int               n_rd [RN];
        bit               taken;
        we     = en && wvs && !p_wvs;
        commit = we && wen;
        e_drop = we && !wen;
        e_wb   = en ? addr(m_wr) : AB'(BASE);
        for (int k = 0; k < RN; k++) begin
            e_rb[k*AB +: AB] = en ? addr(m_rd[k]) : AB'(BASE);
            n_rd[k]  = m_rd[k];
            e_rep[k] = 1'b0;
            re = en && rvs[k] && !p_rvs[k];
            if (re) begin
                if (commit) n_rd[k] = m_wr;
                else if (m_lv != 0 && m_latest != m_rd[k]) n_rd[k] = m_latest;
                else e_rep[k] = 1'b1;
            end
        end
        if (commit) begin
            int old_wr;
            old_wr   = m_wr;
            m_latest = old_wr;
            m_lv     = 1;
            for (int s = 1; s < BN; s++) begin
                taken = 0;
                foreach (m_rd[k]) if (m_rd[k] == (old_wr + s) % BN) taken = 1;
                if (!taken && m_wr == old_wr) m_wr = (old_wr + s) % BN;
            end
        end
        if (we) frames++;
        for (int k = 0; k < RN; k++) m_rd[k] = n_rd[k];
        p_wvs = wvs; p_rvs = rvs;
        @(posedge clk); #1;
        chk("wb",   write_base,  e_wb);
        chk("rb",   read_base,   e_rb);
        chk("rep",  read_repeat, e_rep);
        chk("drop", frame_drop,  e_drop);
    endtask

    initial begin
        int wi, ri, cyc;
        logic collide;
        rst_n = 1'b1; en = 1'b1; wvs = 1'b0; wen = 1'b1; rvs = '0;
        frames = 0;
        #1;
        do_reset();

        // reader sync before any frame completes -> repeat, index held
        tick();
        rvs = 2'b01; tick();
        chk("r31_rep", read_repeat, 64'h1);
        rvs = 2'b00; tick();
        chk("r31_rb0", read_base[AB-1:0], 64'h30_0000);

        // first completed frame, then reader 0 picks it up
        wvs = 1'b1; tick();
        wvs = 1'b0; tick();
        chk("r32_wb", write_base, 64'h10_0000);
        rvs = 2'b01; tick();
        rvs = 2'b00; tick();
        chk("r32_rb0", read_base[AB-1:0], 64'h0);

        // coincident write and read-1 sync
        wvs = 1'b1; rvs = 2'b10; tick();
        wvs = 1'b0; rvs = 2'b00; tick();
        chk("r33_wb",  write_base, 64'h20_0000);
        chk("r33_rb1", read_base[2*AB-1:AB], 64'h10_0000);

        // dropped frame, then repeat on reader already at latest
        wen = 1'b0; wvs = 1'b1; tick();
        chk("r34_drop", frame_drop, 64'h1);
        wvs = 1'b0; wen = 1'b1; tick();
        chk("r34_drop_clr", frame_drop, 64'h0);
        chk("r34_wb", write_base, 64'h20_0000);
        rvs = 2'b10; tick();
        chk("r34_rep", read_repeat, 64'h2);
        rvs = 2'b00; tick();

        // disabled: syncs ignored, bases forced; sync held across enable rising
        en = 1'b0; tick();
        chk("r35_wb_off", write_base, 64'h0);
        chk("r35_rb_off", read_base,  64'h0);
        wvs = 1'b1; rvs = 2'b11; tick();
        tick();
        en = 1'b1; tick();
        chk("r35_wb_on", write_base, 64'h20_0000);
        chk("r35_rb_on", read_base,  {25'h10_0000, 25'h00_0000});
        wvs = 1'b0; rvs = 2'b00; tick();

        // reset mid-operation returns everything immediately
        wvs = 1'b1; tick();
        wvs = 1'b0; tick();
        do_reset();
        tick();

        // random syncs on all ports
        frames = 0; cyc = 0;
        while (frames < 10000 && cyc < 60000) begin
            wvs = 1'($urandom_range(0, 1));
            rvs = RN'($urandom_range(0, (1 << RN) - 1));
            wen = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) en = ~en;
            tick();
            cyc++;
            if (en) begin
                wi = int'(write_base) / FRAME;
                collide = 1'b0;
                for (int k = 0; k < RN; k++) begin
                    ri = int'(read_base[k*AB +: AB]) / FRAME;
                    if (ri == wi) collide = 1'b1;
                end
                chk("excl", collide, 64'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
